// File: rtl/ga_knapsack_fitness_eval_pkg.sv
// Shared definitions for the genetic-algorithm knapsack fitness path: default
// widths used by the evaluator, the core and the selection logic, plus the FSM encoding.
package ga_knapsack_fitness_eval_pkg;

  localparam int unsigned CHROMOSOME_LENGTH = 128;
  localparam int unsigned ITEM_WIDTH        = 8;
  localparam int unsigned LANES             = 8;
  localparam int unsigned FIT_WIDTH         = 16;
  localparam int unsigned ID_WIDTH          = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_t;

endpackage

// File: rtl/ga_knapsack_fitness_eval_if.sv
// Chromosome-in / fitness-out handshake bundle for the fitness evaluator.
// master = population memory side (offers chromosomes, consumes results); slave = evaluator.
interface ga_knapsack_fitness_eval_if #(
  parameter int unsigned ChromosomeLength = ga_knapsack_fitness_eval_pkg::CHROMOSOME_LENGTH,
  parameter int unsigned ItemWidth        = ga_knapsack_fitness_eval_pkg::ITEM_WIDTH,
  parameter int unsigned FitWidth         = ga_knapsack_fitness_eval_pkg::FIT_WIDTH,
  parameter int unsigned IdWidth          = ga_knapsack_fitness_eval_pkg::ID_WIDTH
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [ChromosomeLength-1:0]           in_chromosome;
  logic [IdWidth-1:0]                    in_id;
  logic [ChromosomeLength*ItemWidth-1:0] item_values;
  logic [ChromosomeLength*ItemWidth-1:0] item_weights;
  logic [FitWidth-1:0]                   capacity;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [FitWidth-1:0]                   out_fitness;
  logic [FitWidth-1:0]                   out_weight;
  logic                                  out_feasible;
  logic [IdWidth-1:0]                    out_id;

  modport master (
    output in_valid, in_chromosome, in_id, item_values, item_weights, capacity, out_ready,
    input  in_ready, out_valid, out_fitness, out_weight, out_feasible, out_id
  );

  modport slave (
    input  in_valid, in_chromosome, in_id, item_values, item_weights, capacity, out_ready,
    output in_ready, out_valid, out_fitness, out_weight, out_feasible, out_id
  );
endinterface

// File: rtl/ga_knapsack_fitness_eval_lane_adder.sv
// Combinational masked sum of one chunk of items: each set mask bit adds that
// item's zero-extended value and weight.
module ga_knapsack_fitness_eval_lane_adder #(
  parameter int unsigned Lanes     = 8,
  parameter int unsigned ItemWidth = 8,
  parameter int unsigned FitWidth  = 16
) (
  input  logic [Lanes-1:0]           mask,
  input  logic [Lanes*ItemWidth-1:0] values,
  input  logic [Lanes*ItemWidth-1:0] weights,
  output logic [FitWidth-1:0]        value_sum,
  output logic [FitWidth-1:0]        weight_sum
);

  // Sum the selected lanes
  always_comb begin
    value_sum  = '0;
    weight_sum = '0;
    for (int i = 0; i < Lanes; i++) begin
      if (mask[i]) begin
        value_sum  = value_sum + FitWidth'(values[i*ItemWidth +: ItemWidth]);
        weight_sum = weight_sum + FitWidth'(weights[i*ItemWidth +: ItemWidth]);
      end
    end
  end

endmodule

// File: rtl/ga_knapsack_fitness_eval.sv
// Knapsack fitness evaluator: walks one latched chromosome LANES bits per cycle,
// accumulating packed value and weight, then reports value (or 0 if overweight).
module ga_knapsack_fitness_eval
  import ga_knapsack_fitness_eval_pkg::*;
#(
  parameter int unsigned ChromosomeLength = CHROMOSOME_LENGTH,
  parameter int unsigned ItemWidth        = ITEM_WIDTH,
  parameter int unsigned Lanes            = LANES,
  parameter int unsigned FitWidth         = FIT_WIDTH,
  parameter int unsigned IdWidth          = ID_WIDTH
) (
  input logic                      clk,
  input logic                      rst,
  ga_knapsack_fitness_eval_if.slave bus
);

  localparam int unsigned NumChunks  = ChromosomeLength / Lanes;
  localparam int unsigned ChunkWidth = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned ChunkBits  = Lanes * ItemWidth;
  localparam logic [ChunkWidth-1:0] LastChunk = ChunkWidth'(NumChunks - 1);

  state_t                      state_q, state_d;
  logic [ChunkWidth-1:0]       chunk_q, chunk_d;
  logic [FitWidth-1:0]         value_acc_q, value_acc_d;
  logic [FitWidth-1:0]         weight_acc_q, weight_acc_d;
  logic [ChromosomeLength-1:0] chrom_q, chrom_d;
  logic [IdWidth-1:0]          id_q, id_d;
  logic [FitWidth-1:0]         cap_q, cap_d;
  logic [FitWidth-1:0]         fitness_q, fitness_d;
  logic [FitWidth-1:0]         weight_q, weight_d;
  logic                        feasible_q, feasible_d;
  logic [IdWidth-1:0]          out_id_q, out_id_d;

  logic [Lanes-1:0]            lane_mask;
  logic [FitWidth-1:0]         lane_value, lane_weight;
  logic [FitWidth-1:0]         value_total, weight_total;

  // Single adder shared across chunks; the chunk counter selects its operands
  assign lane_mask = chrom_q[chunk_q*Lanes +: Lanes];

  ga_knapsack_fitness_eval_lane_adder #(
    .Lanes    (Lanes),
    .ItemWidth(ItemWidth),
    .FitWidth (FitWidth)
  ) u_lane_adder (
    .mask      (lane_mask),
    .values    (bus.item_values[chunk_q*ChunkBits +: ChunkBits]),
    .weights   (bus.item_weights[chunk_q*ChunkBits +: ChunkBits]),
    .value_sum (lane_value),
    .weight_sum(lane_weight)
  );

  assign value_total  = value_acc_q + lane_value;
  assign weight_total = weight_acc_q + lane_weight;

  assign bus.in_ready     = (state_q == StIdle);
  assign bus.out_valid    = (state_q == StDone);
  assign bus.out_fitness  = fitness_q;
  assign bus.out_weight   = weight_q;
  assign bus.out_feasible = feasible_q;
  assign bus.out_id       = out_id_q;

  // Next-state: accept, accumulate one chunk per cycle, then hold result until taken
  always_comb begin
    state_d      = state_q;
    chunk_d      = chunk_q;
    value_acc_d  = value_acc_q;
    weight_acc_d = weight_acc_q;
    chrom_d      = chrom_q;
    id_d         = id_q;
    cap_d        = cap_q;
    fitness_d    = fitness_q;
    weight_d     = weight_q;
    feasible_d   = feasible_q;
    out_id_d     = out_id_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          chrom_d      = bus.in_chromosome;
          id_d         = bus.in_id;
          cap_d        = bus.capacity;
          value_acc_d  = '0;
          weight_acc_d = '0;
          chunk_d      = '0;
          state_d      = StAccum;
        end
      end
      StAccum: begin
        value_acc_d  = value_total;
        weight_acc_d = weight_total;
        if (chunk_q == LastChunk) begin
          chunk_d    = '0;
          // Final chunk's sum is folded in directly so the result lands with DONE
          feasible_d = (weight_total <= cap_q);
          fitness_d  = (weight_total <= cap_q) ? value_total : '0;
          weight_d   = weight_total;
          out_id_d   = id_q;
          state_d    = StDone;
        end else begin
          chunk_d = chunk_q + ChunkWidth'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      chunk_q      <= '0;
      value_acc_q  <= '0;
      weight_acc_q <= '0;
      chrom_q      <= '0;
      id_q         <= '0;
      cap_q        <= '0;
      fitness_q    <= '0;
      weight_q     <= '0;
      feasible_q   <= 1'b0;
      out_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      chunk_q      <= chunk_d;
      value_acc_q  <= value_acc_d;
      weight_acc_q <= weight_acc_d;
      chrom_q      <= chrom_d;
      id_q         <= id_d;
      cap_q        <= cap_d;
      fitness_q    <= fitness_d;
      weight_q     <= weight_d;
      feasible_q   <= feasible_d;
      out_id_q     <= out_id_d;
    end
  end

endmodule

// File: tb/tb_ga_knapsack_fitness_eval.sv
// Self-checking bench for the knapsack fitness evaluator: table of directed
// vectors, hand-written stall/reset sequences and random transactions vs. a sum model.
module tb_ga_knapsack_fitness_eval;
  import ga_knapsack_fitness_eval_pkg::*;

  localparam int unsigned CL = CHROMOSOME_LENGTH;
  localparam int NumVecs = 10;

  typedef logic [CL-1:0]        chrom_t;
  typedef logic [FIT_WIDTH-1:0] fit_t;
  typedef logic [ID_WIDTH-1:0]  id_t;

  typedef struct {
    chrom_t                chrom;
    id_t                   id;
    fit_t                  cap;
    logic [ITEM_WIDTH-1:0] val_fill;
    logic [ITEM_WIDTH-1:0] wgt_fill;
    fit_t                  exp_fitness;
    fit_t                  exp_weight;
    logic                  exp_feasible;
  } vec_t;

  typedef struct {
    fit_t fitness;
    fit_t weight;
    logic feasible;
    id_t  id;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [ITEM_WIDTH-1:0] val_tab [CL];
  logic [ITEM_WIDTH-1:0] wgt_tab [CL];
  exp_t sb [$];
  vec_t vecs [NumVecs];

  ga_knapsack_fitness_eval_if bus ();

  ga_knapsack_fitness_eval dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pack_items();
    for (int i = 0; i < CL; i++) begin
      bus.item_values[i*ITEM_WIDTH +: ITEM_WIDTH]  = val_tab[i];
      bus.item_weights[i*ITEM_WIDTH +: ITEM_WIDTH] = wgt_tab[i];
    end
  endtask

  task automatic fill_items(input logic [ITEM_WIDTH-1:0] v, input logic [ITEM_WIDTH-1:0] w);
    for (int i = 0; i < CL; i++) begin
      val_tab[i] = v;
      wgt_tab[i] = w;
    end
    pack_items();
  endtask

  task automatic random_items();
    for (int i = 0; i < CL; i++) begin
      val_tab[i] = ITEM_WIDTH'($urandom_range(0, 255));
      wgt_tab[i] = ITEM_WIDTH'($urandom_range(0, 255));
    end
    pack_items();
  endtask

  function automatic exp_t model(input chrom_t c, input fit_t cap, input id_t id);
    exp_t e;
    int v;
    int w;
    v = 0;
    w = 0;
    for (int i = 0; i < CL; i++) begin
      if (c[i]) begin
        v += int'(val_tab[i]);
        w += int'(wgt_tab[i]);
      end
    end
    e.weight   = fit_t'(w);
    e.feasible = (w <= int'(cap));
    e.fitness  = e.feasible ? fit_t'(v) : '0;
    e.id       = id;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the accept posedge.
  task automatic start_txn(input chrom_t c, input id_t id, input fit_t cap, input exp_t e);
    int guard;
    guard = 0;
    bus.in_valid      = 1'b1;
    bus.in_chromosome = c;
    bus.in_id         = id;
    bus.capacity      = cap;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0, expected 1");
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Waits for the result, optionally stalls it, then takes and scores it.
  task automatic finish_txn(input int stall);
    int   lat;
    exp_t e;
    lat = 1;
    bus.out_ready = (stall == 0);
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 17);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got empty queue, expected pending result");
      return;
    end
    e = sb[0];
    for (int s = 0; s < stall; s++) begin
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_fitness", bus.out_fitness, e.fitness);
      check("stall_id", bus.out_id, e.id);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    e = sb.pop_front();
    check("fitness", bus.out_fitness, e.fitness);
    check("weight", bus.out_weight, e.weight);
    check("feasible", bus.out_feasible, e.feasible);
    check("id", bus.out_id, e.id);
    @(posedge clk);
    @(negedge clk);
    check("out_valid_drop", bus.out_valid, 0);
    check("fitness_retained", bus.out_fitness, e.fitness);
  endtask

  initial begin
    exp_t e;
    exp_t e2;
    chrom_t c;
    fit_t cap;
    int seen;

    n_vec = 0;
    n_err = 0;

    vecs[0] = '{chrom: '1, id: 8'd3, cap: 16'd1373, val_fill: 8'd10, wgt_fill: 8'd5,
                exp_fitness: 16'd1280, exp_weight: 16'd640, exp_feasible: 1'b1};
    vecs[1] = '{chrom: '1, id: 8'd4, cap: 16'd100, val_fill: 8'd10, wgt_fill: 8'd5,
                exp_fitness: 16'd0, exp_weight: 16'd640, exp_feasible: 1'b0};
    vecs[2] = '{chrom: 128'hF_FFFF, id: 8'd5, cap: 16'd100, val_fill: 8'd10, wgt_fill: 8'd5,
                exp_fitness: 16'd200, exp_weight: 16'd100, exp_feasible: 1'b1};
    vecs[3] = '{chrom: '1, id: 8'd6, cap: 16'd65535, val_fill: 8'd255, wgt_fill: 8'd255,
                exp_fitness: 16'd32640, exp_weight: 16'd32640, exp_feasible: 1'b1};
    vecs[4] = '{chrom: '0, id: 8'd7, cap: 16'd0, val_fill: 8'd10, wgt_fill: 8'd5,
                exp_fitness: 16'd0, exp_weight: 16'd0, exp_feasible: 1'b1};
    vecs[5] = '{chrom: {1'b1, 127'b0}, id: 8'd8, cap: 16'd0, val_fill: 8'd10, wgt_fill: 8'd5,
                exp_fitness: 16'd0, exp_weight: 16'd5, exp_feasible: 1'b0};
    vecs[6] = '{chrom: '1, id: 8'd9, cap: 16'd639, val_fill: 8'd10, wgt_fill: 8'd5,
                exp_fitness: 16'd0, exp_weight: 16'd640, exp_feasible: 1'b0};
    vecs[7] = '{chrom: '1, id: 8'd10, cap: 16'd640, val_fill: 8'd10, wgt_fill: 8'd5,
                exp_fitness: 16'd1280, exp_weight: 16'd640, exp_feasible: 1'b1};
    vecs[8] = '{chrom: {32{4'hA}}, id: 8'd255, cap: 16'd65535, val_fill: 8'd7, wgt_fill: 8'd3,
                exp_fitness: 16'd448, exp_weight: 16'd192, exp_feasible: 1'b1};
    vecs[9] = '{chrom: {8'hFF, 120'b0}, id: 8'd1, cap: 16'd65535, val_fill: 8'd1,
                wgt_fill: 8'd200, exp_fitness: 16'd8, exp_weight: 16'd1600, exp_feasible: 1'b1};

    rst               = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_chromosome = '0;
    bus.in_id         = '0;
    bus.capacity      = '0;
    bus.out_ready     = 1'b1;
    fill_items(8'd10, 8'd5);
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_fitness", bus.out_fitness, 0);
    check("rst_weight", bus.out_weight, 0);
    check("rst_feasible", bus.out_feasible, 0);
    check("rst_id", bus.out_id, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table
    for (int k = 0; k < NumVecs; k++) begin
      fill_items(vecs[k].val_fill, vecs[k].wgt_fill);
      e = '{fitness: vecs[k].exp_fitness, weight: vecs[k].exp_weight,
            feasible: vecs[k].exp_feasible, id: vecs[k].id};
      start_txn(vecs[k].chrom, vecs[k].id, vecs[k].cap, e);
      finish_txn(0);
    end

    // Stalled result with a second chromosome held on the input
    fill_items(8'd10, 8'd5);
    e  = '{fitness: 16'd1280, weight: 16'd640, feasible: 1'b1, id: 8'd3};
    e2 = '{fitness: 16'd200, weight: 16'd100, feasible: 1'b1, id: 8'd12};
    start_txn('1, 8'd3, 16'd1373, e);
    bus.in_valid      = 1'b1;
    bus.in_chromosome = 128'hF_FFFF;
    bus.in_id         = 8'd12;
    bus.capacity      = 16'd100;
    finish_txn(5);
    check("held_in_ready_after_handshake", bus.in_ready, 1);
    sb.push_back(e2);
    @(posedge clk);
    @(negedge clk);
    check("held_accepted", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    finish_txn(0);

    // Reset during chunk 7 aborts the transaction
    e = '{fitness: 16'd1280, weight: 16'd640, feasible: 1'b1, id: 8'd3};
    start_txn('1, 8'd3, 16'd1373, e);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_fitness", bus.out_fitness, 0);
    rst = 1'b1;
    void'(sb.pop_back());
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    start_txn('1, 8'd3, 16'd1373, e);
    finish_txn(0);

    // Random transactions against the sum model
    for (int t = 0; t < 1000; t++) begin
      if (t % 100 == 0) random_items();
      c   = {$urandom, $urandom, $urandom, $urandom};
      cap = fit_t'($urandom_range(0, 16000));
      e   = model(c, cap, id_t'(t));
      start_txn(c, id_t'(t), cap, e);
      finish_txn((t % 97 == 5) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
